// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: sequences shared memory, ALU and register file per instruction.
// Optional addi support is enabled by defining MIPS_MC_ADDI_EN.
// state    | meaning
// RESET    | post-reset idle, all controls low
// FETCH    | read instruction, PC += 4 on mem_ready
// DECODE   | register read, branch target precompute
// MEM_ADDR | lw/sw effective address
// MEM_RD   | data read, wait for mem_ready
// MEM_WB   | load writeback to rt
// MEM_WR   | data write, wait for mem_ready
// EXEC     | R-type ALU operation
// ALU_WB   | R-type writeback to rd
// BRANCH   | beq compare and conditional PC load
// JUMP     | jump target PC load
// ADDI_EX  | addi ALU operation
// ADDI_WB  | addi writeback to rt
// TRAP     | illegal opcode, held until reset
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  state_t state_q, state_d;
  // Holds RESET for one extra cycle so release is synchronous to clk.
  logic   rst_sync;

  assign state = state_q;

  always_comb begin
    state_d = S_RESET;
    case (state_q)
      S_RESET:    state_d = rst_sync ? S_FETCH : S_RESET;
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_MC_ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EX;
`endif
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC:     state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
`ifdef MIPS_MC_ADDI_EN
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_ADDI_WB:  state_d = S_FETCH;
`endif
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_RESET;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALU_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
`ifdef MIPS_MC_ADDI_EN
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
`endif
      S_TRAP:     illegal_op = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 1'b0;
      state_q  <= S_RESET;
      retired  <= '0;
    end else begin
      rst_sync <= 1'b1;
      state_q  <= state_d;
      if (instr_done) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl; per-cycle state and control-vector checks.
// Honours MIPS_MC_ADDI_EN the same way as the design.
module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 4;

  // {pw,pwc,iord,mrd,mwr,irw,m2r,rdst,rwr,asa}_asb_aluop_pcsrc_done_ill
  localparam logic [17:0] C_ZERO = 18'b0000000000_00_00_00_0_0;
  localparam logic [17:0] C_F1   = 18'b1001010000_01_00_00_0_0;
  localparam logic [17:0] C_FW   = 18'b0001000000_01_00_00_0_0;
  localparam logic [17:0] C_DEC  = 18'b0000000000_11_00_00_0_0;
  localparam logic [17:0] C_EXE  = 18'b0000000001_00_10_00_0_0;
  localparam logic [17:0] C_AWB  = 18'b0000000110_00_00_00_1_0;
  localparam logic [17:0] C_MAD  = 18'b0000000001_10_00_00_0_0;
  localparam logic [17:0] C_MRD  = 18'b0011000000_00_00_00_0_0;
  localparam logic [17:0] C_MWB  = 18'b0000001010_00_00_00_1_0;
  localparam logic [17:0] C_MW0  = 18'b0010100000_00_00_00_0_0;
  localparam logic [17:0] C_MW1  = 18'b0010100000_00_00_00_1_0;
  localparam logic [17:0] C_BR   = 18'b0100000001_00_01_01_1_0;
  localparam logic [17:0] C_JMP  = 18'b1000000000_00_00_10_1_0;
  localparam logic [17:0] C_AXB  = 18'b0000000010_00_00_00_1_0;
  localparam logic [17:0] C_TRP  = 18'b0000000000_00_00_00_0_1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic             mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [3:0]       state;
  logic             instr_done, illegal_op;
  logic [CNT_W-1:0] retired;
  logic [17:0]      ctl;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_ret = '0;

  assign ctl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op};

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .instr_done(instr_done), .illegal_op(illegal_op),
    .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in FETCH, one step after the second edge following release.
  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tick();
    exp_ret = '0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'h00;
    tick();
    tick();
    checks++;
    if (state !== 4'd0 || ctl !== C_ZERO || retired !== '0) begin
      errors++;
      $display("FAIL reset_hold: state=%0d ctl=%b retired=%0d want 0/0/0", state, ctl, retired);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL reset_release: state=%0d want 0", state);
    end
  endtask

  task automatic test_rtype();
    logic [3:0]  st [5];
    logic [17:0] cv [5];
    st = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd8};
    cv = '{C_ZERO, C_F1, C_DEC, C_EXE, C_AWB};
    opcode = 6'h00;
    mem_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (state !== st[i] || ctl !== cv[i]) begin
        errors++;
        $display("FAIL rtype[%0d]: state=%0d ctl=%b want %0d/%b", i, state, ctl, st[i], cv[i]);
      end
      tick();
    end
    exp_ret = exp_ret + 1'b1;
    checks++;
    if (state !== 4'd1 || retired !== exp_ret) begin
      errors++;
      $display("FAIL rtype_end: state=%0d retired=%0d want 1/%0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_lw_waits();
    logic [3:0]  st [8];
    logic [17:0] cv [8];
    logic        mr [8];
    int          irw = 0;
    st = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd5};
    cv = '{C_FW, C_FW, C_F1, C_DEC, C_MAD, C_MRD, C_MRD, C_MWB};
    mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    opcode = 6'h23;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i];
      #1;
      if (ir_write) irw++;
      checks++;
      if (state !== st[i] || ctl !== cv[i]) begin
        errors++;
        $display("FAIL lw[%0d]: state=%0d ctl=%b want %0d/%b", i, state, ctl, st[i], cv[i]);
      end
      tick();
    end
    exp_ret = exp_ret + 1'b1;
    checks++;
    if (irw != 1 || state !== 4'd1 || retired !== exp_ret) begin
      errors++;
      $display("FAIL lw_end: ir_write_pulses=%0d state=%0d retired=%0d want 1/1/%0d",
               irw, state, retired, exp_ret);
    end
  endtask

  task automatic test_sw_beq_j();
    logic [3:0]  st [11];
    logic [17:0] cv [11];
    logic        mr [11];
    logic [5:0]  op [11];
    st = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd10};
    cv = '{C_F1, C_DEC, C_MAD, C_MW0, C_MW1, C_F1, C_DEC, C_BR, C_F1, C_DEC, C_JMP};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    op = '{6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h04, 6'h04, 6'h04, 6'h02, 6'h02, 6'h02};
    for (int i = 0; i < 11; i++) begin
      mem_ready = mr[i];
      opcode    = op[i];
      #1;
      checks++;
      if (state !== st[i] || ctl !== cv[i]) begin
        errors++;
        $display("FAIL sbj[%0d]: state=%0d ctl=%b want %0d/%b", i, state, ctl, st[i], cv[i]);
      end
      tick();
    end
    exp_ret = exp_ret + 4'd3;
    checks++;
    if (state !== 4'd1 || retired !== exp_ret) begin
      errors++;
      $display("FAIL sbj_end: state=%0d retired=%0d want 1/%0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_addi();
`ifdef MIPS_MC_ADDI_EN
    logic [3:0]  st [4];
    logic [17:0] cv [4];
    st = '{4'd1, 4'd2, 4'd11, 4'd12};
    cv = '{C_F1, C_DEC, C_MAD, C_AXB};
    opcode = 6'h08;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (state !== st[i] || ctl !== cv[i]) begin
        errors++;
        $display("FAIL addi[%0d]: state=%0d ctl=%b want %0d/%b", i, state, ctl, st[i], cv[i]);
      end
      tick();
    end
    exp_ret = exp_ret + 1'b1;
    checks++;
    if (state !== 4'd1 || retired !== exp_ret) begin
      errors++;
      $display("FAIL addi_end: state=%0d retired=%0d want 1/%0d", state, retired, exp_ret);
    end
`else
    logic [3:0]  st [3];
    logic [17:0] cv [3];
    st = '{4'd1, 4'd2, 4'd15};
    cv = '{C_F1, C_DEC, C_TRP};
    opcode = 6'h08;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (state !== st[i] || ctl !== cv[i]) begin
        errors++;
        $display("FAIL addi_off[%0d]: state=%0d ctl=%b want %0d/%b", i, state, ctl, st[i], cv[i]);
      end
      tick();
    end
    do_reset();
`endif
  endtask

  task automatic test_trap();
    opcode = 6'h3F;
    mem_ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      #1;
      checks++;
      if (state !== 4'd15 || ctl !== C_TRP) begin
        errors++;
        $display("FAIL trap[%0d]: state=%0d ctl=%b want 15/%b", i, state, ctl, C_TRP);
      end
      tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || ctl !== C_ZERO || retired !== '0) begin
      errors++;
      $display("FAIL trap_clear: state=%0d ctl=%b retired=%0d want 0/0/0", state, ctl, retired);
    end
    do_reset();
  endtask

  task automatic test_wrap_and_abort();
    logic [3:0] st [3];
    st = '{4'd1, 4'd2, 4'd10};
    opcode = 6'h02;
    mem_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      for (int i = 0; i < 3; i++) begin
        #1;
        checks++;
        if (state !== st[i]) begin
          errors++;
          $display("FAIL wrap_j%0d[%0d]: state=%0d want %0d", k, i, state, st[i]);
        end
        tick();
      end
    end
    checks++;
    if (retired !== 4'd1) begin
      errors++;
      $display("FAIL wrap_count: retired=%0d want 1", retired);
    end
    opcode = 6'h23;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 4'd4 || ctl !== C_MRD) begin
      errors++;
      $display("FAIL abort_pre: state=%0d ctl=%b want 4/%b", state, ctl, C_MRD);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || ctl !== C_ZERO || retired !== '0) begin
      errors++;
      $display("FAIL abort_reset: state=%0d ctl=%b retired=%0d want 0/0/0", state, ctl, retired);
    end
    mem_ready = 1'b1;
    do_reset();
    checks++;
    if (state !== 4'd1 || retired !== '0) begin
      errors++;
      $display("FAIL abort_restart: state=%0d retired=%0d want 1/0", state, retired);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_waits();
    test_sw_beq_j();
    test_addi();
    test_trap();
    test_wrap_and_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
